cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
- Main control state machine of the 16-bit CPU. Sits directly downstream of the instruction register and consumes the opcode field, opcode = IR[15:13].
- Generates every per-cycle strobe for a two-byte fetch over the 8-bit data bus, then one execute phase.
- Drives the PC, the accumulator, the memory read/write lines, the data-bus output driver and the IR load enable.
- Counts retired instructions.

Parameters:
CNT_W, 16, width of retired-instruction counter icount

Ports:
clk  in  1  clock, all state updated on rising edge
rst  in  1  synchronous reset, active-high
ena  in  1  run enable; low = sequencer idles in S0
opcode  in  3  IR[15:13]; 000 HLT, 001 SKZ, 010 ADD, 011 AND, 100 XOR, 101 LDA, 110 STO, 111 JMP
zero  in  1  accumulator-zero flag
rd  out  1  memory read strobe
wr  out  1  memory write strobe
load_ir  out  1  IR byte-load enable; drives IR ena
inc_pc  out  1  PC increment by one byte
load_pc  out  1  PC load from IR[12:0]
load_acc  out  1  accumulator load from ALU
datactl_ena  out  1  drive accumulator onto data bus
halt  out  1  processor halted
state  out  3  current state, for debug
icount  out  CNT_W  retired-instruction count

Behaviour:
- Reset: rst is synchronous and active-high; clk is the clock. On a clk edge with rst=1: state=S0, icount=0, halted flag cleared.
- While rst=1, all strobes and halt are forced to 0 combinationally.
- States are S0..S5 (encoded 0..5) plus HALT (encoded 7). Encoding 6 is illegal and goes to S0 next cycle with all outputs 0.
- Strobes are combinational decodes of the registered state, opcode and zero. Opcode is stable from S2 on, because the IR completes on the edge ending S1.
- ena=0 at any edge (rst=0): next state = S0, no strobes in that cycle. This abandons any partial instruction.
- In HALT, ena is ignored.
- Per state, outputs and transitions (strobes not listed are 0):
- S0: rd=1, load_ir=1, inc_pc=1. Fetches the high byte. Next S1.
- S1: rd=1, load_ir=1, inc_pc=1. Fetches the low byte. Next S2.
  - load_ir must fall after exactly 2 cycles so the IR byte pointer returns to its high-byte position.
- S2: decode, no strobes. Next S3.
- S3, by opcode:
  - HLT: halt=1, next HALT.
  - SKZ: inc_pc = zero.
  - ADD, AND, XOR, LDA: rd=1.
  - STO: datactl_ena=1.
  - JMP: load_pc=1.
  - Next S4 for every opcode except HLT.
- S4, by opcode:
  - SKZ: inc_pc = zero. Two increments skip one 2-byte instruction.
  - ADD, AND, XOR, LDA: rd=1, load_acc=1.
  - STO: datactl_ena=1, wr=1.
  - Next S5.
- S5: no strobes. icount increments at the edge leaving S5; the counter wraps modulo 2^CNT_W. Next S0.
- HALT: halt=1, no other strobes. Exit only via rst.
- Throughput is 6 cycles per non-HLT instruction with ena held high.
- wr and rd are never high in the same cycle. wr is high only while datactl_ena is high.
- zero is sampled in S3 and S4 independently; a change between them is honoured per cycle.
- rst and ena=0 in the same cycle: rst wins (icount cleared).
- ena dropping in S5: the instruction is not counted.
- ena=0 while in HALT: remains HALT.
- ena rising from idle: S0 strobes appear in the same cycle ena is high and state=S0.

Test Plan:
- Reset: rst=1 for 2 cycles with ena=1 -> state=0, icount=0, all strobes 0 during rst. First cycle after release: rd=1, load_ir=1, inc_pc=1.
- LDA (opcode 101), ena=1: strobe sequence S0..S5 matches the table; rd high in cycles 0, 1, 3, 4; load_acc only in cycle 4; icount=1 after 6 cycles; state returns to 0.
- STO (110): datactl_ena=1 in S3 and S4, wr=1 only in S4, rd=0 in S3 and S4. Check rd&wr never 1 over 100 random cycles.
- SKZ (001): zero=1 -> inc_pc high in S0, S1, S3, S4 (4 pulses). zero=0 -> 2 pulses. Also zero=1 in S3 and 0 in S4 -> exactly 3 pulses.
- HLT (000) at icount=5: halt=1 from S3 onward, state=7, no strobes for 20 cycles with ena toggling. rst -> state=0, halt=0, icount=0.
- Abort and wrap: ena=0 during S1 -> next state 0, load_ir low, icount unchanged. With CNT_W=2, run 5 ADD instructions -> icount reads 1.

Source files
------------

// File: rtl/cpu_sequencer_if.sv
// Control bundle between the CPU datapath and its main sequencer.
// The sequencer takes the slave modport; the datapath or a bench takes the master modport.
interface cpu_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ena;
    logic [2:0]       opcode;
    logic             zero;
    logic             rd;
    logic             wr;
    logic             load_ir;
    logic             inc_pc;
    logic             load_pc;
    logic             load_acc;
    logic             datactl_ena;
    logic             halt;
    logic [2:0]       state;
    logic [CNT_W-1:0] icount;

    modport master (
        output ena, opcode, zero,
        input  rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, state, icount
    );

    modport slave (
        input  ena, opcode, zero,
        output rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt, state, icount
    );
endinterface

// File: rtl/cpu_sequencer.sv
// Main CPU control FSM: two-byte fetch (S0,S1), decode (S2), two execute cycles (S3,S4),
// retire (S5), plus a sticky HALT state; counts retired instructions.
module cpu_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    cpu_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S0     = 3'd0,
        S1     = 3'd1,
        S2     = 3'd2,
        S3     = 3'd3,
        S4     = 3'd4,
        S5     = 3'd5,
        S_ILL  = 3'd6,
        S_HALT = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_HLT = 3'd0,
        OP_SKZ = 3'd1,
        OP_ADD = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_LDA = 3'd5,
        OP_STO = 3'd6,
        OP_JMP = 3'd7
    } op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] icount_q, icount_d;
    op_t              op;

    logic rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt;

    assign op = op_t'(bus.opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S0;
            icount_q <= '0;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    always_comb begin
        state_d     = S0;
        icount_d    = icount_q;
        rd          = 1'b0;
        wr          = 1'b0;
        load_ir     = 1'b0;
        inc_pc      = 1'b0;
        load_pc     = 1'b0;
        load_acc    = 1'b0;
        datactl_ena = 1'b0;
        halt        = 1'b0;

        // HALT ignores ena; otherwise ena low abandons the instruction and idles in S0.
        if (state_q == S_HALT) begin
            state_d = S_HALT;
            halt    = 1'b1;
        end else if (bus.ena) begin
            case (state_q)
                S0, S1: begin
                    rd      = 1'b1;
                    load_ir = 1'b1;
                    inc_pc  = 1'b1;
                    state_d = (state_q == S0) ? S1 : S2;
                end
                S2: state_d = S3;
                S3: begin
                    state_d = S4;
                    case (op)
                        OP_HLT: begin
                            halt    = 1'b1;
                            state_d = S_HALT;
                        end
                        OP_SKZ:                        inc_pc      = bus.zero;
                        OP_ADD, OP_AND, OP_XOR, OP_LDA: rd          = 1'b1;
                        OP_STO:                        datactl_ena = 1'b1;
                        default:                       load_pc     = 1'b1;
                    endcase
                end
                S4: begin
                    state_d = S5;
                    case (op)
                        OP_SKZ: inc_pc = bus.zero;
                        OP_ADD, OP_AND, OP_XOR, OP_LDA: begin
                            rd       = 1'b1;
                            load_acc = 1'b1;
                        end
                        OP_STO: begin
                            datactl_ena = 1'b1;
                            wr          = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S5: begin
                    state_d  = S0;
                    icount_d = icount_q + CNT_W'(1);
                end
                default: state_d = S0;
            endcase
        end

        if (rst) begin
            rd          = 1'b0;
            wr          = 1'b0;
            load_ir     = 1'b0;
            inc_pc      = 1'b0;
            load_pc     = 1'b0;
            load_acc    = 1'b0;
            datactl_ena = 1'b0;
            halt        = 1'b0;
        end
    end

    assign bus.rd          = rd;
    assign bus.wr          = wr;
    assign bus.load_ir     = load_ir;
    assign bus.inc_pc      = inc_pc;
    assign bus.load_pc     = load_pc;
    assign bus.load_acc    = load_acc;
    assign bus.datactl_ena = datactl_ena;
    assign bus.halt        = halt;
    assign bus.state       = state_q;
    assign bus.icount      = icount_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: a wide-counter and a 2-bit-counter instance share stimulus and are
// compared each cycle against an instruction-phase reference model.
module tb_cpu_sequencer;

    logic clk;
    logic rst;

    cpu_sequencer_if #(.CNT_W(16)) bus16 ();
    cpu_sequencer_if #(.CNT_W(2))  bus2 ();

    cpu_sequencer #(.CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
    cpu_sequencer #(.CNT_W(2))  dut2  (.clk(clk), .rst(rst), .bus(bus2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model: position within the instruction, halted flag, retired count.
    int unsigned m_phase;
    bit          m_halted;
    int unsigned m_count;

    // Observed pulse tallies, cleared by the directed sequences.
    int unsigned n_rd, n_wr, n_inc, n_acc, n_dctl, n_ldir, n_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Order: {rd, wr, load_ir, inc_pc, load_pc, load_acc, datactl_ena, halt}
    function automatic logic [7:0] expected_strobes(input logic r, input logic e,
                                                    input logic [2:0] op, input logic z);
        logic [7:0] s;
        s = 8'h00;
        if (r)             s = 8'h00;
        else if (m_halted) s = 8'h01;
        else if (!e)       s = 8'h00;
        else if (m_phase < 2) s = 8'b1011_0000;
        else if (m_phase == 3) begin
            if (op == 3'd0)      s = 8'h01;
            else if (op == 3'd1) s = {3'b000, z, 4'b0000};
            else if (op <= 3'd5) s = 8'b1000_0000;
            else if (op == 3'd6) s = 8'b0000_0010;
            else                 s = 8'b0000_1000;
        end else if (m_phase == 4) begin
            if (op == 3'd1)      s = {3'b000, z, 4'b0000};
            else if (op >= 3'd2 && op <= 3'd5) s = 8'b1000_0100;
            else if (op == 3'd6) s = 8'b0100_0010;
        end
        return s;
    endfunction

    function automatic logic [7:0] strobes16();
        return {bus16.rd, bus16.wr, bus16.load_ir, bus16.inc_pc,
                bus16.load_pc, bus16.load_acc, bus16.datactl_ena, bus16.halt};
    endfunction

    function automatic logic [7:0] strobes2();
        return {bus2.rd, bus2.wr, bus2.load_ir, bus2.inc_pc,
                bus2.load_pc, bus2.load_acc, bus2.datactl_ena, bus2.halt};
    endfunction

    // One clock cycle: drive at posedge+1, check at the falling edge, advance the model at posedge.
    task automatic step(input logic r, input logic e, input logic [2:0] op, input logic z);
        logic [7:0] exp_s;
        rst = r;
        bus16.ena = e; bus16.opcode = op; bus16.zero = z;
        bus2.ena  = e; bus2.opcode  = op; bus2.zero  = z;
        #4;
        exp_s = expected_strobes(r, e, op, z);
        check("strobes", 32'(strobes16()), 32'(exp_s));
        check("strobes_w2", 32'(strobes2()), 32'(exp_s));
        check("state", 32'(bus16.state), m_halted ? 32'd7 : 32'(m_phase));
        check("icount", 32'(bus16.icount), m_count % 65536);
        check("icount_w2", 32'(bus2.icount), m_count % 4);
        check("rd_and_wr", 32'(bus16.rd & bus16.wr), 32'd0);
        n_rd   += 32'(bus16.rd);
        n_wr   += 32'(bus16.wr);
        n_inc  += 32'(bus16.inc_pc);
        n_acc  += 32'(bus16.load_acc);
        n_dctl += 32'(bus16.datactl_ena);
        n_ldir += 32'(bus16.load_ir);
        n_halt += 32'(bus16.halt);
        @(posedge clk);
        if (r) begin
            m_phase = 0; m_halted = 1'b0; m_count = 0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!e) begin
            m_phase = 0;
        end else if (m_phase == 3 && op == 3'd0) begin
            m_halted = 1'b1;
        end else if (m_phase == 5) begin
            m_phase = 0;
            m_count++;
        end else begin
            m_phase++;
        end
        #1;
    endtask

    task automatic clear_tallies();
        n_rd = 0; n_wr = 0; n_inc = 0; n_acc = 0; n_dctl = 0; n_ldir = 0; n_halt = 0;
    endtask

    // Full six-cycle instruction with separate zero values for the two execute cycles.
    task automatic run_instr(input logic [2:0] op, input logic z3, input logic z4);
        clear_tallies();
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b1, op, (i == 3) ? z3 : (i == 4) ? z4 : 1'($urandom_range(0, 1)));
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 3'd5, 1'b0);
        step(1'b1, 1'b1, 3'd5, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        bus16.ena = 1'b0; bus16.opcode = 3'd0; bus16.zero = 1'b0;
        bus2.ena  = 1'b0; bus2.opcode  = 3'd0; bus2.zero  = 1'b0;
        m_phase = 0; m_halted = 1'b0; m_count = 0;
        clear_tallies();
        @(posedge clk);
        #1;

        do_reset();

        run_instr(3'd5, 1'b0, 1'b0);
        check("lda_rd_pulses", n_rd, 4);
        check("lda_acc_pulses", n_acc, 1);
        check("lda_ldir_pulses", n_ldir, 2);
        check("lda_icount", 32'(bus16.icount), 1);

        run_instr(3'd6, 1'b0, 1'b0);
        check("sto_wr_pulses", n_wr, 1);
        check("sto_dctl_pulses", n_dctl, 2);
        check("sto_rd_pulses", n_rd, 2);

        run_instr(3'd1, 1'b1, 1'b1);
        check("skz_11_inc", n_inc, 4);
        run_instr(3'd1, 1'b0, 1'b0);
        check("skz_00_inc", n_inc, 2);
        run_instr(3'd1, 1'b1, 1'b0);
        check("skz_10_inc", n_inc, 3);

        check("pre_hlt_icount", 32'(bus16.icount), 5);
        clear_tallies();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 3'd0, 1'b0);
        check("hlt_state", 32'(bus16.state), 7);
        clear_tallies();
        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        check("halted_strobes", n_rd + n_wr + n_inc + n_acc + n_dctl + n_ldir, 0);
        check("halted_halt_pulses", n_halt, 20);
        check("halted_icount", 32'(bus16.icount), 5);
        step(1'b1, 1'b0, 3'd0, 1'b0);
        step(1'b0, 1'b0, 3'd2, 1'b0);
        check("post_rst_halt", 32'(bus16.halt), 0);

        step(1'b0, 1'b1, 3'd2, 1'b0);
        step(1'b0, 1'b0, 3'd2, 1'b0);
        check("abort_state", 32'(bus16.state), 0);
        check("abort_ldir", 32'(bus16.load_ir), 0);
        check("abort_icount", 32'(bus16.icount), 0);

        do_reset();
        for (int k = 0; k < 5; k++) run_instr(3'd2, 1'b0, 1'b0);
        check("wrap_icount_w2", 32'(bus2.icount), 1);
        check("wide_icount", 32'(bus16.icount), 5);

        for (int i = 0; i < 600; i++) begin
            logic       r, e, z;
            logic [2:0] op;
            r  = m_halted ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 49) == 0);
            e  = ($urandom_range(0, 9) != 0);
            op = ($urandom_range(0, 29) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            z  = 1'($urandom_range(0, 1));
            step(r, e, op, z);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
